// File: rtl/l1_cache.sv
// Direct-mapped, write-through, write-allocate L1 data cache.
// Exchanges whole lines with L2 using a level request and a one-cycle l2_ready pulse.
module l1_cache #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 11,
    parameter int CACHE_SIZE    = 64,
    parameter int L1_BLOCK_SIZE = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [ADDR_WIDTH-1:0]                 cpu_addr,
    input  logic [DATA_WIDTH-1:0]                 cpu_wdata,
    input  logic                                  cpu_read,
    input  logic                                  cpu_write,
    output logic [DATA_WIDTH-1:0]                 cpu_rdata,
    output logic                                  cpu_ready,
    output logic                                  cpu_hit,
    output logic                                  busy,
    output logic [ADDR_WIDTH-1:0]                 l2_addr,
    output logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0]   l2_wdata,
    output logic                                  l2_read,
    output logic                                  l2_write,
    input  logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0]   l2_rdata,
    input  logic                                  l2_ready
);

    localparam int LINES = CACHE_SIZE / L1_BLOCK_SIZE;
    localparam int OFF   = $clog2(L1_BLOCK_SIZE);
    localparam int IDX   = $clog2(LINES);
    localparam int TAG   = ADDR_WIDTH - IDX - OFF;
    localparam int BLK_W = L1_BLOCK_SIZE * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, LOOKUP, FETCH, WTHRU} state_t;

    state_t                  state, state_d;
    logic [ADDR_WIDTH-1:0]   req_addr, req_addr_d;
    logic [DATA_WIDTH-1:0]   req_wdata, req_wdata_d;
    logic                    req_write, req_write_d;
    logic                    req_hit, req_hit_d;

    logic [DATA_WIDTH-1:0]   cpu_rdata_d;
    logic                    cpu_ready_d, cpu_hit_d;
    logic [ADDR_WIDTH-1:0]   l2_addr_d;
    logic [BLK_W-1:0]        l2_wdata_d;
    logic                    l2_read_d, l2_write_d;

    logic [TAG-1:0]          tag_mem  [LINES];
    logic [BLK_W-1:0]        data_mem [LINES];
    logic [LINES-1:0]        valid;

    logic [TAG-1:0]          req_tag;
    logic [IDX-1:0]          req_idx;
    logic [OFF-1:0]          req_off;
    logic [BLK_W-1:0]        cur_line, merged_hit, merged_fill, line_wdata;
    logic                    hit, line_we;

    assign req_tag  = req_addr[ADDR_WIDTH-1:IDX+OFF];
    assign req_idx  = req_addr[IDX+OFF-1:OFF];
    assign req_off  = req_addr[OFF-1:0];
    assign cur_line = data_mem[req_idx];
    assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);

    // Store word spliced into either the resident line or the freshly fetched block.
    always_comb begin
        merged_hit  = cur_line;
        merged_fill = l2_rdata;
        merged_hit[req_off*DATA_WIDTH +: DATA_WIDTH]  = req_wdata;
        merged_fill[req_off*DATA_WIDTH +: DATA_WIDTH] = req_wdata;
    end

    always_comb begin
        state_d     = state;
        req_addr_d  = req_addr;
        req_wdata_d = req_wdata;
        req_write_d = req_write;
        req_hit_d   = req_hit;
        cpu_rdata_d = cpu_rdata;
        cpu_ready_d = 1'b0;
        cpu_hit_d   = cpu_hit;
        l2_addr_d   = l2_addr;
        l2_wdata_d  = l2_wdata;
        l2_read_d   = l2_read;
        l2_write_d  = l2_write;
        line_we     = 1'b0;
        line_wdata  = '0;

        unique case (state)
            IDLE: begin
                if (cpu_read || cpu_write) begin
                    req_addr_d  = cpu_addr;
                    req_wdata_d = cpu_wdata;
                    req_write_d = cpu_write;
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                req_hit_d = hit;
                if (hit && !req_write) begin
                    cpu_rdata_d = cur_line[req_off*DATA_WIDTH +: DATA_WIDTH];
                    cpu_ready_d = 1'b1;
                    cpu_hit_d   = 1'b1;
                    state_d     = IDLE;
                end else if (hit) begin
                    line_we    = 1'b1;
                    line_wdata = merged_hit;
                    l2_wdata_d = merged_hit;
                    l2_addr_d  = {req_tag, req_idx, {OFF{1'b0}}};
                    l2_write_d = 1'b1;
                    state_d    = WTHRU;
                end else begin
                    l2_addr_d = {req_tag, req_idx, {OFF{1'b0}}};
                    l2_read_d = 1'b1;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                if (l2_ready) begin
                    line_we   = 1'b1;
                    l2_read_d = 1'b0;
                    if (!req_write) begin
                        line_wdata  = l2_rdata;
                        cpu_rdata_d = l2_rdata[req_off*DATA_WIDTH +: DATA_WIDTH];
                        cpu_ready_d = 1'b1;
                        cpu_hit_d   = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        line_wdata = merged_fill;
                        l2_wdata_d = merged_fill;
                        l2_write_d = 1'b1;
                        state_d    = WTHRU;
                    end
                end
            end
            WTHRU: begin
                if (l2_ready) begin
                    l2_write_d  = 1'b0;
                    cpu_ready_d = 1'b1;
                    cpu_hit_d   = req_hit;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_addr  <= '0;
            req_wdata <= '0;
            req_write <= 1'b0;
            req_hit   <= 1'b0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            cpu_hit   <= 1'b0;
            busy      <= 1'b0;
            l2_addr   <= '0;
            l2_wdata  <= '0;
            l2_read   <= 1'b0;
            l2_write  <= 1'b0;
            valid     <= '0;
        end else begin
            state     <= state_d;
            req_addr  <= req_addr_d;
            req_wdata <= req_wdata_d;
            req_write <= req_write_d;
            req_hit   <= req_hit_d;
            cpu_rdata <= cpu_rdata_d;
            cpu_ready <= cpu_ready_d;
            cpu_hit   <= cpu_hit_d;
            busy      <= (state_d != IDLE);
            l2_addr   <= l2_addr_d;
            l2_wdata  <= l2_wdata_d;
            l2_read   <= l2_read_d;
            l2_write  <= l2_write_d;
            if (line_we) valid[req_idx] <= 1'b1;
        end
    end

    // Tag and data arrays hold no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[req_idx]  <= req_tag;
            data_mem[req_idx] <= line_wdata;
        end
    end

endmodule

// File: tb/tb_l1_cache.sv
// Directed self-checking bench for l1_cache; the bench plays the L2 side by hand.
module tb_l1_cache;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [10:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_read, cpu_write;
    logic [31:0]   cpu_rdata;
    logic          cpu_ready, cpu_hit, busy;
    logic [10:0]   l2_addr;
    logic [127:0]  l2_wdata, l2_rdata;
    logic          l2_read, l2_write, l2_ready;

    int checks   = 0;
    int failures = 0;

    l1_cache #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .CACHE_SIZE(64), .L1_BLOCK_SIZE(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .busy(busy),
        .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_read(l2_read), .l2_write(l2_write),
        .l2_rdata(l2_rdata), .l2_ready(l2_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_req(input logic rd, input logic wr, input logic [10:0] a, input logic [31:0] d);
        @(negedge clk);
        cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
        @(posedge clk);
        #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    // which: 0 = l2_read, 1 = l2_write, 2 = cpu_ready
    task automatic wait_flag(input int which, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if ((which == 0 && l2_read) || (which == 1 && l2_write) || (which == 2 && cpu_ready))
                seen = 1'b1;
            else
                @(negedge clk);
        end
        chk(tag, {127'd0, seen}, 128'd1);
    endtask

    task automatic l2_respond(input logic [127:0] blk, input int delay);
        repeat (delay) @(negedge clk);
        l2_rdata = blk; l2_ready = 1'b1;
        @(negedge clk);
        l2_ready = 1'b0; l2_rdata = '0;
    endtask

    initial begin
        rst_n = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_read = 1'b0; cpu_write = 1'b0;
        l2_rdata = '0; l2_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", cpu_ready, 0);
        chk("rst_hit", cpu_hit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_l2rw", {l2_read, l2_write}, 0);
        chk("rst_l2addr", l2_addr, 0);
        chk("rst_l2wdata", l2_wdata, 0);
        rst_n = 1'b1;

        // Read miss 0x045
        cpu_req(1, 0, 11'h045, 0);
        wait_flag(0, "miss_l2read");
        chk("miss_l2addr", l2_addr, 11'h044);
        chk("miss_busy", busy, 1);
        chk("miss_nowrite", l2_write, 0);
        repeat (2) @(negedge clk);
        chk("fetch_hold", {l2_read, l2_addr}, {1'b1, 11'h044});
        l2_respond({32'h44, 32'h33, 32'h22, 32'h11}, 0);
        wait_flag(2, "miss_ready");
        chk("miss_rdata", cpu_rdata, 32'h22);
        chk("miss_hit", cpu_hit, 0);
        chk("miss_l2drop", l2_read, 0);

        // Read hit 0x047: ready exactly two edges after request
        cpu_req(1, 0, 11'h047, 0);
        @(negedge clk);
        chk("hit_ready_early", {cpu_ready, l2_read}, 0);
        @(negedge clk);
        chk("hit_ready", cpu_ready, 1);
        chk("hit_rdata", cpu_rdata, 32'h44);
        chk("hit_hit", cpu_hit, 1);
        chk("hit_nol2", {l2_read, l2_write}, 0);
        @(negedge clk);
        chk("hit_pulse", {cpu_ready, busy}, 0);

        // l2_ready while idle is ignored
        l2_respond({4{32'hFFFF_FFFF}}, 0);
        chk("idle_l2ready", {cpu_ready, busy, l2_read, l2_write}, 0);

        // Write hit 0x046
        cpu_req(0, 1, 11'h046, 32'hDEADBEEF);
        wait_flag(1, "whit_l2write");
        chk("whit_l2addr", l2_addr, 11'h044);
        chk("whit_l2wdata", l2_wdata, {32'h44, 32'hDEADBEEF, 32'h22, 32'h11});
        chk("whit_noread", l2_read, 0);
        repeat (2) @(negedge clk);
        chk("whit_wait", {cpu_ready, l2_write}, 2'b01);
        l2_respond('0, 0);
        wait_flag(2, "whit_ready");
        chk("whit_hit", cpu_hit, 1);
        chk("whit_l2drop", l2_write, 0);
        cpu_req(1, 0, 11'h046, 0);
        repeat (2) @(negedge clk);
        chk("rdback", {cpu_ready, cpu_hit, cpu_rdata}, {2'b11, 32'hDEADBEEF});

        // Conflict miss 0x0C5 then re-miss 0x045
        cpu_req(1, 0, 11'h0C5, 0);
        wait_flag(0, "conf_l2read");
        chk("conf_l2addr", l2_addr, 11'h0C4);
        l2_respond({32'h88, 32'h77, 32'h66, 32'h55}, 2);
        wait_flag(2, "conf_ready");
        chk("conf_rdata", {cpu_hit, cpu_rdata}, {1'b0, 32'h66});
        cpu_req(1, 0, 11'h045, 0);
        wait_flag(0, "evict_l2read");
        chk("evict_l2addr", l2_addr, 11'h044);
        l2_respond({32'h44, 32'hDEADBEEF, 32'h22, 32'h11}, 1);
        wait_flag(2, "evict_ready");
        chk("evict_rdata", {cpu_hit, cpu_rdata}, {1'b0, 32'h22});

        // Write miss 0x100
        cpu_req(0, 1, 11'h100, 32'hA5);
        wait_flag(0, "wmiss_l2read");
        chk("wmiss_l2addr", l2_addr, 11'h100);
        l2_respond({32'd4, 32'd3, 32'd2, 32'd1}, 2);
        wait_flag(1, "wmiss_l2write");
        chk("wmiss_exclusive", l2_read, 0);
        chk("wmiss_l2wdata", l2_wdata, {32'd4, 32'd3, 32'd2, 32'hA5});
        chk("wmiss_waddr", l2_addr, 11'h100);
        l2_respond('0, 1);
        wait_flag(2, "wmiss_ready");
        chk("wmiss_hit", cpu_hit, 0);

        // Reset during FETCH
        cpu_req(1, 0, 11'h200, 0);
        wait_flag(0, "rstf_l2read");
        rst_n = 1'b0;
        #1;
        chk("rstf_drop", {l2_read, busy, cpu_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cpu_req(1, 0, 11'h047, 0);
        wait_flag(0, "rstf_remiss");
        chk("rstf_l2addr", l2_addr, 11'h044);
        l2_respond({32'h44, 32'h33, 32'h22, 32'h11}, 1);
        wait_flag(2, "rstf_ready");
        chk("rstf_rdata", {cpu_hit, cpu_rdata}, {1'b0, 32'h44});

        // Read and write together: write wins
        cpu_req(1, 1, 11'h047, 32'h12345678);
        wait_flag(1, "both_l2write");
        chk("both_noread", l2_read, 0);
        chk("both_l2wdata", l2_wdata, {32'h12345678, 32'h33, 32'h22, 32'h11});
        l2_respond('0, 1);
        wait_flag(2, "both_ready");
        chk("both_hit", cpu_hit, 1);
        cpu_req(1, 0, 11'h047, 0);
        repeat (2) @(negedge clk);
        chk("both_rdback", {cpu_ready, cpu_hit, cpu_rdata}, {2'b11, 32'h12345678});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1_cache.md
Name: l1_cache

Overview:
- Direct-mapped, write-through, write-allocate L1 data cache between the CPU load/store port and L2_cache.
- Serves single-word CPU reads and writes.
- Exchanges whole L1 blocks with L2 over a level-based request / l2_ready-pulse handshake.
- Addresses are word addresses.

Parameters:
- DATA_WIDTH, 32, bits per word.
- ADDR_WIDTH, 11, word-address width, shared with L2.
- CACHE_SIZE, 64, total words held.
- L1_BLOCK_SIZE, 4, words per line (power of 2).
- Derived: LINES=CACHE_SIZE/L1_BLOCK_SIZE (16); OFF=$clog2(L1_BLOCK_SIZE) (2); IDX=$clog2(LINES) (4); TAG=ADDR_WIDTH-IDX-OFF (5).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_addr  in  ADDR_WIDTH  word address.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_read  in  1  load request.
- cpu_write  in  1  store request.
- cpu_rdata  out  DATA_WIDTH  load data; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_hit  out  1  qualifies cpu_ready: 1=hit, 0=miss.
- busy  out  1  high in every state except IDLE.
- l2_addr  out  ADDR_WIDTH  block-aligned address (offset bits zero).
- l2_wdata  out  L1_BLOCK_SIZE*DATA_WIDTH  block to L2; word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- l2_read  out  1  block fetch request.
- l2_write  out  1  block write-through request.
- l2_rdata  in  L1_BLOCK_SIZE*DATA_WIDTH  fetched block; same word packing as l2_wdata.
- l2_ready  in  1  one-cycle pulse: L2 done; l2_rdata valid in that cycle.

Behaviour:
- Storage: per line TAG bits, valid bit, L1_BLOCK_SIZE words. Address fields: tag=[ADDR_WIDTH-1:IDX+OFF], index=[IDX+OFF-1:OFF], offset=[OFF-1:0].
- All outputs are registered. Reset values: cpu_rdata=0, cpu_ready=0, cpu_hit=0, busy=0, l2_addr=0, l2_wdata=0, l2_read=0, l2_write=0. All valid bits cleared. Tag and data arrays are not reset.
- State IDLE:
  - If cpu_read or cpu_write is high at a clock edge: capture addr, wdata and op into req registers, go LOOKUP.
  - If both are high, write wins.
- State LOOKUP (hit = valid[idx] && tag match):
  - Read hit: cpu_rdata <= line word[off], cpu_ready=cpu_hit=1 for one cycle, go IDLE.
  - Read hit latency: request sampled at edge N, cpu_ready high after edge N+1.
  - Write hit: write word[off] into line; l2_wdata <= updated line; l2_addr <= {tag,idx,0}; l2_write <= 1; go WTHRU.
  - Any miss: l2_addr <= {tag,idx,0}; l2_read <= 1; go FETCH.
- State FETCH: hold l2_read=1 and l2_addr stable until l2_ready. On l2_ready:
  - Install l2_rdata, tag, valid=1. The previous line contents are discarded; no dirty data exists under write-through.
  - Read: cpu_rdata <= l2_rdata word[off], cpu_ready=1, cpu_hit=0, go IDLE.
  - Write: install the block with word[off] replaced by req wdata; l2_wdata <= merged block; l2_write <= 1; l2_read <= 0; go WTHRU. The miss is remembered so the final cpu_hit=0.
- State WTHRU: hold l2_write, l2_addr and l2_wdata until l2_ready. Then l2_write <= 0, cpu_ready=1, cpu_hit = hit-or-miss recorded at LOOKUP, go IDLE.
- l2_read and l2_write are never high together. Each drops in the cycle after its l2_ready.
- l2_ready outside FETCH/WTHRU is ignored.
- CPU request changes while busy are ignored; captured req registers are used throughout.
- CPU must drop its request in the cycle after cpu_ready. If a request is still high in IDLE, it is accepted as a new request.
- No timeout; an absent l2_ready stalls indefinitely.
- Reset asserted mid-operation: immediate return to IDLE, all outputs to reset values, all lines invalid. An in-flight L2 request is abandoned.

Test Plan:
- After reset, read addr 0x045 with L2 returning block {0x11,0x22,0x33,0x44} (l2_ready 3 cycles after l2_read) -> l2_addr=0x044, cpu_rdata=0x22, cpu_hit=0.
- Then read 0x047 -> no L2 traffic, cpu_ready two edges after request with cpu_rdata=0x44, cpu_hit=1.
- Write 0xDEADBEEF to 0x046 (hit) -> l2_write=1, l2_addr=0x044, l2_wdata={0x11,0x22,0xDEADBEEF,0x44}. cpu_ready only after l2_ready, with cpu_hit=1. A subsequent read of 0x046 hits and returns 0xDEADBEEF.
- Conflict: read 0x0C5 (same index 1, tag differs) -> miss, refill evicts line. Re-read 0x045 -> miss again with l2_read.
- Write miss to 0x100 with data 0xA5 and L2 block {1,2,3,4} -> l2_read, then l2_write with {0xA5,2,3,4}; cpu_hit=0.
- Assert rst_n=0 while in FETCH -> l2_read drops immediately, busy=0. A read to the previously loaded address then misses.
- cpu_read and cpu_write high together -> write performed.
